// File: rtl/fxp_pkg.sv
// fxp_pkg: shared fixed-point widths, limits and default fraction size
package fxp_pkg;
    localparam int FRAC_DEFAULT = 8;
    localparam int Q_WIDTH = 16;
    localparam int PROD_WIDTH = 32;
    localparam logic [Q_WIDTH-1:0] MAX_POS = 16'h7FFF;
    localparam logic [Q_WIDTH-1:0] MAX_NEG = 16'h8000;
endpackage

// File: rtl/fxp_round_sat.sv
// fxp_round_sat: round-half-away-from-zero of a product magnitude and Q-format saturation
//   mag  : unsigned product magnitude            -> r    : rounded magnitude (33 bits)
//   sign : sign of the registered rounded value,
//   rq   : registered rounded magnitude          -> data : two's-complement result, sat : clamped
module fxp_round_sat import fxp_pkg::*; #(
    parameter int FRAC = FRAC_DEFAULT
) (
    input  logic [PROD_WIDTH-1:0] mag,
    output logic [PROD_WIDTH:0]   r,
    input  logic                  sign,
    input  logic [PROD_WIDTH:0]   rq,
    output logic [Q_WIDTH-1:0]    data,
    output logic                  sat
);
    // Adding half an LSB before truncating a magnitude rounds half away from zero.
    localparam logic [PROD_WIDTH:0] HALF = (33'd1 << FRAC) >> 1;
    localparam logic [PROD_WIDTH:0] POS_LIM = {{(PROD_WIDTH+1-Q_WIDTH){1'b0}}, MAX_POS};
    localparam logic [PROD_WIDTH:0] NEG_LIM = {{(PROD_WIDTH+1-Q_WIDTH){1'b0}}, MAX_NEG};
    logic pos_ovf;
    logic neg_ovf;
    always_comb begin
        r = ({1'b0, mag} + HALF) >> FRAC;
        pos_ovf = !sign && rq > POS_LIM;
        neg_ovf = sign && rq > NEG_LIM;
        sat = pos_ovf || neg_ovf;
        data = pos_ovf ? MAX_POS : neg_ovf ? MAX_NEG : sign ? -rq[Q_WIDTH-1:0] : rq[Q_WIDTH-1:0];
    end
endmodule

// File: rtl/fxp_product_formatter.sv
// fxp_product_formatter: two-stage pipeline turning a sign/magnitude product into a saturated Q-format word
//   clk, rst                          : clock, asynchronous active-high reset
//   in_valid/in_ready, in_sign,
//   in_mag_hi/in_mag_lo               : product input handshake and payload
//   out_valid/out_ready, out_data,
//   out_sat                           : formatted result handshake and payload
//   sat_count                         : saturated results delivered, sticks at 0xFFFF
module fxp_product_formatter import fxp_pkg::*; #(
    parameter int FRAC = FRAC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [15:0]        in_mag_hi,
    input  logic [15:0]        in_mag_lo,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Q_WIDTH-1:0] out_data,
    output logic               out_sat,
    output logic [15:0]        sat_count
);
    logic                s1_valid;
    logic                s1_sign;
    logic [PROD_WIDTH:0] s1_r;
    logic [PROD_WIDTH:0] r;
    logic [Q_WIDTH-1:0]  data;
    logic                sat;
    logic                s2_adv;

    fxp_round_sat #(.FRAC(FRAC)) u_round_sat (
        .mag  ({in_mag_hi, in_mag_lo}),
        .r    (r),
        .sign (s1_sign),
        .rq   (s1_r),
        .data (data),
        .sat  (sat)
    );

    assign s2_adv = !out_valid || out_ready;
    // S1 empties into S2 whenever S2 advances, so a full S1 can still accept.
    assign in_ready = !s1_valid || s2_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign <= 1'b0;
            s1_r <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_sat <= 1'b0;
            sat_count <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sign <= in_sign;
                    s1_r <= r;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= data;
                    out_sat <= sat;
                end
            end
            if (out_valid && out_ready && out_sat && sat_count != 16'hFFFF)
                sat_count <= sat_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_fxp_product_formatter.sv
// tb_fxp_product_formatter: randomized and directed self-checking bench for fxp_product_formatter
module tb_fxp_product_formatter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [15:0] in_mag_hi = '0;
    logic [15:0] in_mag_lo = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_sat;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;
    int exp_sat = 0;
    logic [16:0] exp_q[$];

    fxp_product_formatter #(.FRAC(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_mag_hi (in_mag_hi),
        .in_mag_lo (in_mag_lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    // Reference: integer division gives the truncated value, remainder >= half rounds up.
    function automatic logic [16:0] model(input logic s, input logic [31:0] m);
        longint r;
        longint v;
        r = longint'(m) / 256 + ((longint'(m) % 256) >= 128 ? 1 : 0);
        if (!s && r > 32767) return {1'b1, 16'h7FFF};
        if (s && r > 32768) return {1'b1, 16'h8000};
        v = s ? (65536 - r) % 65536 : r;
        return {1'b0, v[15:0]};
    endfunction

    function automatic logic [31:0] pick_mag();
        case ($urandom % 5)
            0: return $urandom;
            1: return $urandom % 1024;
            2: return 32'h007F_FF00 + ($urandom % 512);
            3: return 32'h0080_0000 + ($urandom % 512) - 256;
            default: return $urandom % 32'h0100_0000;
        endcase
    endfunction

    // Drives one cycle of inputs, samples the handshake just before the edge and advances past it.
    task automatic step(input logic v, input logic s, input logic [31:0] m, input logic ordy,
                        output logic took, output logic gave, output logic ov,
                        output logic [15:0] d, output logic sat);
        in_valid = v;
        in_sign = s;
        in_mag_hi = m[31:16];
        in_mag_lo = m[15:0];
        out_ready = ordy;
        #1;
        took = in_valid && in_ready;
        gave = out_valid && out_ready;
        ov = out_valid;
        d = out_data;
        sat = out_sat;
        if (took) exp_q.push_back(model(s, m));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sat !== 1'b0 || sat_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h sat=%b cnt=%h expected 0/0000/0/0000",
                     out_valid, out_data, out_sat, sat_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic        vs[9] = '{0, 0, 0, 1, 1, 1, 0, 1, 1};
        logic [31:0] vm[9] = '{32'h0003_0000, 32'h80, 32'h7F, 32'h80, 32'h7F, 32'h0003_0000,
                               32'h0080_0000, 32'h0080_0000, 32'h0080_0080};
        logic [15:0] vd[9] = '{16'h0300, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 16'hFD00,
                               16'h7FFF, 16'h8000, 16'h8000};
        logic        vsat[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
        logic took, gave, ov, sat;
        logic [15:0] d;
        int lat;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, vs[i], vm[i], 1'b1, took, gave, ov, d, sat);
            checks++;
            if (!took) begin
                errors++;
                $display("FAIL basic_accept[%0d]: in_ready low on idle pipeline", i);
            end
            lat = 0;
            gave = 1'b0;
            while (!gave && lat < 8) begin
                step(1'b0, 1'($urandom), $urandom, 1'b1, took, gave, ov, d, sat);
                lat++;
            end
            checks++;
            if (!gave || lat != 2 || d !== vd[i] || sat !== vsat[i]) begin
                errors++;
                $display("FAIL basic_vec[%0d]: gave=%b lat=%0d data=%h sat=%b expected lat=2 data=%h sat=%b",
                         i, gave, lat, d, sat, vd[i], vsat[i]);
            end
            if (gave && exp_q.size() > 0) void'(exp_q.pop_front());
            if (gave && vsat[i]) exp_sat++;
        end
        checks++;
        if (sat_count !== 16'd2) begin
            errors++;
            $display("FAIL basic_sat_count: got %0d expected 2", sat_count);
        end
    endtask

    task automatic test_backpressure();
        logic        vs[4];
        logic [31:0] vm[4];
        logic took, gave, ov, sat, held_sat;
        logic [15:0] d, held_d;
        logic [16:0] e;
        int idx = 0;
        int delivered = 0;
        logic prev_ov = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vs[i] = 1'($urandom);
            vm[i] = pick_mag();
        end
        vm[1] = 32'h0100_0000;
        held_d = '0;
        held_sat = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, vs[idx], vm[idx], 1'b0, took, gave, ov, d, sat);
            if (took) idx++;
            if (prev_ov) begin
                checks++;
                if (!ov || d !== held_d || sat !== held_sat) begin
                    errors++;
                    $display("FAIL bp_hold: valid=%b data=%h sat=%b expected 1/%h/%b", ov, d, sat, held_d, held_sat);
                end
            end
            if (ov && !prev_ov) begin
                held_d = d;
                held_sat = sat;
            end
            prev_ov = ov;
        end
        checks++;
        if (idx != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: accepted=%0d in_ready=%b expected 2/0", idx, in_ready);
        end
        for (int c = 0; c < 20 && delivered < 4; c++) begin
            step(idx < 4, vs[idx % 4], vm[idx % 4], 1'b1, took, gave, ov, d, sat);
            if (took) idx++;
            if (gave) begin
                e = exp_q.pop_front();
                checks++;
                if (d !== e[15:0] || sat !== e[16]) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: data=%h sat=%b expected %h/%b", delivered, d, sat, e[15:0], e[16]);
                end
                if (e[16]) exp_sat++;
                delivered++;
            end
        end
        checks++;
        if (delivered != 4) begin
            errors++;
            $display("FAIL bp_drain: delivered %0d expected 4", delivered);
        end
    endtask

    task automatic test_random();
        logic took, gave, ov, sat;
        logic [15:0] d;
        logic [16:0] e;
        int bad = 0;
        int n = 0;
        for (int c = 0; c < 600; c++) begin
            step(($urandom % 4) != 0, 1'($urandom), pick_mag(), ($urandom % 3) != 0, took, gave, ov, d, sat);
            if (gave) begin
                e = exp_q.pop_front();
                n++;
                checks++;
                if (d !== e[15:0] || sat !== e[16]) begin
                    errors++;
                    if (bad++ < 10)
                        $display("FAIL rand_data[%0d]: data=%h sat=%b expected %h/%b", n, d, sat, e[15:0], e[16]);
                end
                if (e[16]) exp_sat++;
            end
        end
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            step(1'b0, 1'($urandom), $urandom, 1'b1, took, gave, ov, d, sat);
            if (gave) begin
                e = exp_q.pop_front();
                checks++;
                if (d !== e[15:0] || sat !== e[16]) begin
                    errors++;
                    $display("FAIL rand_drain: data=%h sat=%b expected %h/%b", d, sat, e[15:0], e[16]);
                end
                if (e[16]) exp_sat++;
            end
        end
        checks++;
        if (exp_q.size() != 0 || n < 100) begin
            errors++;
            $display("FAIL rand_complete: pending=%0d delivered=%0d expected 0 pending, >=100 delivered", exp_q.size(), n);
        end
        checks++;
        if (sat_count !== 16'(exp_sat)) begin
            errors++;
            $display("FAIL rand_sat_count: got %0d expected %0d", sat_count, exp_sat);
        end
    endtask

    task automatic test_reset_midstream();
        logic took, gave, ov, sat;
        logic [15:0] d;
        int delivered = 0;
        logic [15:0] first_d = '0;
        step(1'b1, 1'b0, 32'h0100_0000, 1'b0, took, gave, ov, d, sat);
        step(1'b1, 1'b1, 32'h0100_0000, 1'b0, took, gave, ov, d, sat);
        checks++;
        if (!took || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_fill: took=%b out_valid=%b expected 1/1", took, out_valid);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sat !== 1'b0 || sat_count !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_clear: valid=%b data=%h sat=%b cnt=%h expected 0/0000/0/0000",
                     out_valid, out_data, out_sat, sat_count);
        end
        exp_q.delete();
        exp_sat = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_ready: got %b expected 1", in_ready);
        end
        step(1'b1, 1'b0, 32'h0003_0000, 1'b1, took, gave, ov, d, sat);
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 1'($urandom), $urandom, 1'b1, took, gave, ov, d, sat);
            if (gave) begin
                if (delivered == 0) first_d = d;
                delivered++;
            end
        end
        checks++;
        if (delivered != 1 || first_d !== 16'h0300 || sat_count !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_after: delivered=%0d first=%h cnt=%0d expected 1/0300/0", delivered, first_d, sat_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fxp_product_formatter.md
FXP_PRODUCT_FORMATTER -- requirements
Module: fxp_product_formatter

Interface
REQ-001 SHALL have parameter FRAC, default 8, meaning the number of fractional bits per operand (legal 0..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port in_valid  input  1  product word present.
REQ-005 SHALL have port in_ready  output  1  formatter accepts a product this cycle.
REQ-006 SHALL have port in_sign  input  1  product sign, 1 = negative.
REQ-007 SHALL have port in_mag_hi  input  16  upper half of the unsigned product magnitude.
REQ-008 SHALL have port in_mag_lo  input  16  lower half of the unsigned product magnitude.
REQ-009 SHALL have port out_valid  output  1  formatted result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port out_data  output  16  two's-complement result in the operand Q-format.
REQ-012 SHALL have port out_sat  output  1  out_data was clamped.
REQ-013 SHALL have port sat_count  output  16  number of saturated results delivered, sticks at 0xFFFF.

Function
REQ-014 SHALL accept an input on a clk edge where in_valid and in_ready are both 1, with mag = {in_mag_hi, in_mag_lo}.
REQ-015 SHALL be a two-stage pipeline: S1 registers sign and rounded magnitude; S2 registers out_data, out_sat and out_valid.
REQ-016 SHALL round half away from zero: r = (mag >> FRAC) + mag[FRAC-1] when FRAC > 0, else r = mag; r is carried as 33 bits so no overflow is possible.
REQ-017 SHALL saturate positives: if sign = 0 and r > 0x7FFF, then out_data = 0x7FFF and out_sat = 1.
REQ-018 SHALL saturate negatives: if sign = 1 and r > 0x8000, then out_data = 0x8000 and out_sat = 1; r = 0x8000 exactly gives out_data = 0x8000 with out_sat = 0.
REQ-019 SHALL otherwise output out_data = sign ? -r[15:0] : r[15:0] with out_sat = 0; a negative sign with r = 0 gives out_data = 0x0000.
REQ-020 SHALL have latency of 2 edges from acceptance to out_valid = 1 when not stalled, with a throughput of 1 result per cycle.
REQ-021 SHALL advance S2 when !S2.valid or out_ready, and SHALL set in_ready = !S1.valid or S1 advancing (combinational, no bubble).
REQ-022 SHALL hold out_data, out_sat and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL, when accepting and handing over in the same cycle, allow both to occur with no loss or duplication of data.
REQ-024 SHALL increment sat_count on each edge where out_valid, out_ready and out_sat are all 1, and SHALL not wrap past 0xFFFF.
REQ-025 SHALL ignore in_sign and in_mag_hi/in_mag_lo when in_valid = 0.

Reset
REQ-026 SHALL, when rst = 1, immediately clear S1.valid and S2.valid, and set out_valid = 0, out_data = 0x0000, out_sat = 0 and sat_count = 0x0000.
REQ-027 SHALL discard in-flight products on a reset mid-operation; the first result after reset SHALL be the first input accepted after rst falls.
REQ-028 SHALL drive in_ready = 1 in the first cycle after reset release.

Structure
REQ-029 SHALL take from shared package fxp_pkg: FRAC default, Q_WIDTH = 16, PROD_WIDTH = 32, MAX_POS = 0x7FFF, MAX_NEG = 0x8000.
REQ-030 SHALL place the rounding and saturation logic in one combinational sub-module, fxp_round_sat (sign, mag, FRAC -> data, sat); pipeline registers and handshake stay in the top module.

Verification (FRAC = 8)
REQ-031 SHALL verify basic: sign 0, mag 0x00030000 (1.5 x 2.0) -> out_data 0x0300, out_sat 0, 2 edges after acceptance.
REQ-032 SHALL verify rounding: mag 0x00000080 -> 0x0001; mag 0x0000007F -> 0x0000; sign 1, mag 0x00000080 -> 0xFFFF.
REQ-033 SHALL verify negative zero and negative: sign 1, mag 0x0000007F -> 0x0000; sign 1, mag 0x00030000 -> 0xFD00.
REQ-034 SHALL verify saturation: sign 0, mag 0x00800000 -> 0x7FFF with sat 1; sign 1, mag 0x00800000 -> 0x8000 with sat 0; sign 1, mag 0x00800080 -> 0x8000 with sat 1; sat_count = 2.
REQ-035 SHALL verify backpressure: 4 back-to-back inputs with out_ready held 0 for 5 cycles -> in_ready drops after 2 accepts, outputs are held stable, and all 4 results emerge in order once out_ready = 1.
REQ-036 SHALL verify reset mid-stream: rst asserted while S1 and S2 are full -> out_valid = 0 immediately, the old results are never delivered, and sat_count = 0.
